// File: rtl/activation_pkg.sv
// ----------------------------------------------------------------------------
// activation_pkg : shared fixed-point types and FSM states for activation blocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package activation_pkg;

  localparam int          FRAC_BITS = 12;
  localparam logic [15:0] FIXED_ONE = 16'h1000;

  typedef logic signed [15:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_mult.sv
// ----------------------------------------------------------------------------
// seq_mult : radix-2 shift-add multiplier, signed x unsigned, 16 iterations
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_mult #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start_i,
  input  logic signed [W-1:0]   mcand_i,
  input  logic        [W-1:0]   mplier_i,
  output logic                  done_o,
  output logic signed [2*W-1:0] product_o
);

  localparam int CW = $clog2(W);

  logic signed [2*W-1:0] acc_q, acc_d;
  logic signed [2*W-1:0] mcand_q, mcand_d;
  logic        [W-1:0]   mplier_q, mplier_d;
  logic        [CW-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic signed [2*W-1:0] w_mcand_ext;

  assign w_mcand_ext = {{W{mcand_i[W-1]}}, mcand_i};

  // The start edge already performs the bit-0 step, so the product is
  // complete after 15 further edges and done is seen in the 16th cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start_i) begin
      acc_d    = mplier_i[0] ? w_mcand_ext : '0;
      mcand_d  = w_mcand_ext <<< 1;
      mplier_d = mplier_i >> 1;
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q <<< 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(W-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/sigmoid_backprop.sv
// ----------------------------------------------------------------------------
// sigmoid_backprop : grad = err * y * (1 - y), Q4.12, one shared multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sigmoid_backprop
  import activation_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] err_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] grad_out
);

  state_t state_q, state_d;
  fixed_t err_q, err_d;
  fixed_t grad_q, grad_d;

  logic                       w_mul_start;
  logic signed [DATA_W-1:0]   w_mul_a;
  logic        [DATA_W-1:0]   w_mul_b;
  logic                       w_mul_done;
  logic signed [2*DATA_W-1:0] w_prod;
  logic        [DATA_W-1:0]   w_prod_q412;
  logic        [DATA_W-1:0]   w_y_clamp;
  logic                       w_unused_bits;

  seq_mult #(
    .W (DATA_W)
  ) u_mult (
    .clk       (clk),
    .n_rst     (n_rst),
    .start_i   (w_mul_start),
    .mcand_i   (w_mul_a),
    .mplier_i  (w_mul_b),
    .done_o    (w_mul_done),
    .product_o (w_prod)
  );

  // Both the unsigned p and the floored signed gradient are the same slice.
  assign w_prod_q412   = w_prod[FRAC_BITS+DATA_W-1:FRAC_BITS];
  assign w_unused_bits = ^{w_prod[2*DATA_W-1:FRAC_BITS+DATA_W], w_prod[FRAC_BITS-1:0]};

  always_comb begin
    if (y_in[DATA_W-1]) begin
      w_y_clamp = '0;
    end else if (y_in > FIXED_ONE) begin
      w_y_clamp = FIXED_ONE;
    end else begin
      w_y_clamp = y_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    grad_d      = grad_q;
    w_mul_start = 1'b0;
    w_mul_a     = '0;
    w_mul_b     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = MUL1;
          err_d       = err_in;
          w_mul_start = 1'b1;
          w_mul_a     = w_y_clamp;
          w_mul_b     = FIXED_ONE - w_y_clamp;
        end
      end
      MUL1: begin
        if (w_mul_done) begin
          state_d     = MUL2;
          w_mul_start = 1'b1;
          w_mul_a     = err_q;
          w_mul_b     = w_prod_q412;
        end
      end
      MUL2: begin
        if (w_mul_done) begin
          state_d = DONE;
          grad_d  = w_prod_q412;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      err_q   <= '0;
      grad_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      grad_q  <= grad_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign grad_out  = grad_q;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_backprop.sv
// ----------------------------------------------------------------------------
// tb_sigmoid_backprop : directed bench with a reference model for sigmoid_backprop
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sigmoid_backprop;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] y_in = '0;
  logic [15:0] err_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] grad_out;

  int checks = 0;
  int errors = 0;

  sigmoid_backprop #(
    .DATA_W    (16),
    .FRAC_BITS (12)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .err_in    (err_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out)
  );

  always #5 clk = ~clk;

  // Gradient from plain integer arithmetic on real-valued fixed-point numbers.
  function automatic logic [15:0] model_grad(input logic [15:0] y, input logic [15:0] e);
    int     yc;
    int     p;
    longint prod;
    if (y[15])              yc = 0;
    else if (y > 16'h1000)  yc = 4096;
    else                    yc = int'(y);
    p    = (yc * (4096 - yc)) / 4096;
    prod = longint'($signed(e)) * longint'(p);
    return 16'(prod >>> 12);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy from accept until handshake, result after 32 edges.
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_grad = '0;
  logic [15:0] m_last = '0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_grad = '0;
      m_last = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_grad = model_grad(y_in, err_in);
      end
    end else if (m_cnt >= 32) begin
      if (out_ready) m_busy = 1'b0;
    end else begin
      m_cnt++;
      if (m_cnt == 32) m_last = m_grad;
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      chk("model_in_ready",  32'(in_ready),  32'(!m_busy));
      chk("model_out_valid", 32'(out_valid), 32'(m_busy && m_cnt >= 32));
      chk("model_grad_out",  32'(grad_out),  32'(m_last));
    end
  end

  // Assumes the caller is at negedge+1 with the DUT idle.
  task automatic txn(input logic [15:0] y, input logic [15:0] e,
                     input logic [15:0] exp, input int stall);
    int lat;
    bit got;
    y_in      = y;
    err_in    = e;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    if (stall == 0) in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk("latency", 32'(lat), 32'd32);
    chk("grad_literal", 32'(grad_out), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_grad",      32'(grad_out),  32'(exp));
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready",  32'(in_ready),  32'd1);
    chk("post_hs_grad_hold", 32'(grad_out),  32'(exp));
    #1;
  endtask

  initial begin
    #3;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_grad",      32'(grad_out),  32'd0);
    repeat (2) @(negedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    #1;

    txn(16'h0800, 16'h1000, 16'h0400, 0);
    txn(16'h0400, 16'hF000, 16'hFD00, 0);
    txn(16'h0000, 16'h7FFF, 16'h0000, 0);
    txn(16'h1000, 16'h7FFF, 16'h0000, 0);
    txn(16'h9000, 16'h7FFF, 16'h0000, 0);
    txn(16'h2000, 16'h7FFF, 16'h0000, 0);
    txn(16'h0800, 16'h8000, 16'hE000, 0);
    txn(16'h0C00, 16'hE000, 16'hFA00, 0);
    txn(16'h0100, 16'h1000, 16'h00F0, 0);
    txn(16'h0800, 16'h3000, 16'h0C00, 10);
    txn(16'h0100, 16'hFFFF, 16'hFFFF, 0);

    // Reset during the 10th MUL1 cycle; previous grad_out is nonzero.
    y_in     = 16'h0800;
    err_in   = 16'h1000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_grad",      32'(grad_out),  32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    #1;
    txn(16'h0800, 16'h1000, 16'h0400, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
